// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the issue scoreboard slice.
//   LEN_REGNO / LEN_IMM_EX : register-number and extended-immediate widths
//   LEN_STALLCNT           : width of the saturating stall counter
//   NUM_REG                : number of general registers tracked
//   isb_state_e            : drain/flush sequencer states
package issue_scoreboard_pkg;

    localparam int unsigned LEN_REGNO    = 4;
    localparam int unsigned LEN_IMM_EX   = 32;
    localparam int unsigned LEN_STALLCNT = 16;
    localparam int unsigned NUM_REG      = 2 ** LEN_REGNO;

    typedef enum logic [1:0] {
        ISB_RUN   = 2'd0,
        ISB_DRAIN = 2'd1,
        ISB_DONE  = 2'd2
    } isb_state_e;

endpackage

// File: rtl/issue_scoreboard_bits.sv
// Pending-write flags, one per general register.
//   clk, rst        : clock, asynchronous active-low reset
//   set_i, set_r_i  : reserve register set_r_i at the next edge
//   clr_i, clr_r_i  : writeback of register clr_r_i (bypassed into lookups)
//   rd_i, rs_i      : registers to look up
//   rd_pend_o       : effective pending flag of rd_i
//   rs_pend_o       : effective pending flag of rs_i
//   pending_o       : registered pending vector
//   pending_next_o  : value the pending vector takes at the next edge
module issue_scoreboard_bits #(
    parameter int unsigned LEN_REGNO = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set_i,
    input  logic [LEN_REGNO-1:0]     set_r_i,
    input  logic                     clr_i,
    input  logic [LEN_REGNO-1:0]     clr_r_i,
    input  logic [LEN_REGNO-1:0]     rd_i,
    input  logic [LEN_REGNO-1:0]     rs_i,
    output logic                     rd_pend_o,
    output logic                     rs_pend_o,
    output logic [2**LEN_REGNO-1:0]  pending_o,
    output logic [2**LEN_REGNO-1:0]  pending_next_o
);

    localparam int unsigned NUM_REG = 2 ** LEN_REGNO;

    logic [NUM_REG-1:0] pending_q, pending_d;
    logic [NUM_REG-1:0] set_mask, clr_mask, pend_eff;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_i) set_mask[set_r_i] = 1'b1;
        if (clr_i) clr_mask[clr_r_i] = 1'b1;
        // Writeback clears before the set is OR-ed in, so a same-cycle
        // reservation of the written-back register survives.
        pend_eff  = pending_q & ~clr_mask;
        pending_d = pend_eff | set_mask;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pending_q <= '0;
        else      pending_q <= pending_d;
    end

    always_comb begin
        rd_pend_o      = pend_eff[rd_i];
        rs_pend_o      = pend_eff[rs_i];
        pending_o      = pending_q;
        pending_next_o = pending_d;
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue scoreboard between the instruction decoder and the execute stage.
//   clk, rst                      : clock, asynchronous active-low reset
//   dec_valid_i / dec_ready_o     : decoder handshake
//   rd_i, rs_i, immf_i, imm_i     : decoded operands
//   rd_rd_i, rd_wr_i              : rd read as source / rd written
//   iss_valid_o / iss_ready_i     : issue register handshake to execute
//   iss_rd_o .. iss_imm_o         : issue register payload
//   w_reserved_o, res_r_o         : reservation strobe to register_general
//   wb_i, wb_r_i                  : writeback strobe and register
//   pending_o                     : pending-write vector
//   flush_i, flush_done_o         : drain request, one-cycle done pulse
//   stall_cnt_o                   : saturating count of stalled decoder cycles
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int unsigned LEN_REGNO    = issue_scoreboard_pkg::LEN_REGNO,
    parameter int unsigned LEN_IMM_EX   = issue_scoreboard_pkg::LEN_IMM_EX,
    parameter int unsigned LEN_STALLCNT = issue_scoreboard_pkg::LEN_STALLCNT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dec_valid_i,
    output logic                     dec_ready_o,
    input  logic [LEN_REGNO-1:0]     rd_i,
    input  logic [LEN_REGNO-1:0]     rs_i,
    input  logic                     immf_i,
    input  logic [LEN_IMM_EX-1:0]    imm_i,
    input  logic                     rd_rd_i,
    input  logic                     rd_wr_i,
    output logic                     iss_valid_o,
    input  logic                     iss_ready_i,
    output logic [LEN_REGNO-1:0]     iss_rd_o,
    output logic [LEN_REGNO-1:0]     iss_rs_o,
    output logic                     iss_immf_o,
    output logic [LEN_IMM_EX-1:0]    iss_imm_o,
    output logic                     w_reserved_o,
    output logic [LEN_REGNO-1:0]     res_r_o,
    input  logic                     wb_i,
    input  logic [LEN_REGNO-1:0]     wb_r_i,
    output logic [2**LEN_REGNO-1:0]  pending_o,
    input  logic                     flush_i,
    output logic                     flush_done_o,
    output logic [LEN_STALLCNT-1:0]  stall_cnt_o
);

    localparam logic [LEN_STALLCNT-1:0] STALL_ONE = {{(LEN_STALLCNT-1){1'b0}}, 1'b1};

    logic                      rd_pend, rs_pend, hazard, free, run, accept, set_en;
    logic [2**LEN_REGNO-1:0]   pending_next;

    isb_state_e                state_q, state_d;
    logic                      flush_done_q, flush_done_d;

    logic                      iss_valid_q, iss_valid_d;
    logic [LEN_REGNO-1:0]      iss_rd_q, iss_rd_d, iss_rs_q, iss_rs_d;
    logic                      iss_immf_q, iss_immf_d;
    logic [LEN_IMM_EX-1:0]     iss_imm_q, iss_imm_d;
    logic [LEN_STALLCNT-1:0]   stall_cnt_q, stall_cnt_d;

    issue_scoreboard_bits #(
        .LEN_REGNO (LEN_REGNO)
    ) u_bits (
        .clk            (clk),
        .rst            (rst),
        .set_i          (set_en),
        .set_r_i        (rd_i),
        .clr_i          (wb_i),
        .clr_r_i        (wb_r_i),
        .rd_i           (rd_i),
        .rs_i           (rs_i),
        .rd_pend_o      (rd_pend),
        .rs_pend_o      (rs_pend),
        .pending_o      (pending_o),
        .pending_next_o (pending_next)
    );

    // Hazard check and decoder handshake
    always_comb begin
        hazard       = (rd_pend & (rd_rd_i | rd_wr_i)) | (rs_pend & ~immf_i);
        free         = ~iss_valid_q | iss_ready_i;
        dec_ready_o  = run & free & ~hazard;
        accept       = dec_valid_i & dec_ready_o;
        set_en       = accept & rd_wr_i;
        w_reserved_o = set_en;
        res_r_o      = rd_i;
    end

    // Issue register and stall counter
    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_rd_d    = iss_rd_q;
        iss_rs_d    = iss_rs_q;
        iss_immf_d  = iss_immf_q;
        iss_imm_d   = iss_imm_q;
        stall_cnt_d = stall_cnt_q;
        if (accept) begin
            iss_valid_d = 1'b1;
            iss_rd_d    = rd_i;
            iss_rs_d    = rs_i;
            iss_immf_d  = immf_i;
            iss_imm_d   = imm_i;
        end else if (iss_ready_i) begin
            iss_valid_d = 1'b0;
        end
        if (dec_valid_i && !dec_ready_o && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + STALL_ONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_valid_q <= 1'b0;
            iss_rd_q    <= '0;
            iss_rs_q    <= '0;
            iss_immf_q  <= 1'b0;
            iss_imm_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_rd_q    <= iss_rd_d;
            iss_rs_q    <= iss_rs_d;
            iss_immf_q  <= iss_immf_d;
            iss_imm_q   <= iss_imm_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        iss_valid_o = iss_valid_q;
        iss_rd_o    = iss_rd_q;
        iss_rs_o    = iss_rs_q;
        iss_immf_o  = iss_immf_q;
        iss_imm_o   = iss_imm_q;
        stall_cnt_o = stall_cnt_q;
    end

    // Drain sequencer: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ISB_RUN;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_done_q <= flush_done_d;
        end
    end

    // Drain sequencer: next state. The drained test looks at next-edge
    // values so a final writeback/retire moves to DONE on that same edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ISB_RUN:   if (flush_i) state_d = ISB_DRAIN;
            ISB_DRAIN: if (pending_next == '0 && !iss_valid_d) state_d = ISB_DONE;
            ISB_DONE:  state_d = ISB_RUN;
            default:   state_d = ISB_RUN;
        endcase
        flush_done_d = (state_d == ISB_DONE);
    end

    // Drain sequencer: outputs
    always_comb begin
        run          = (state_q == ISB_RUN);
        flush_done_o = flush_done_q;
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
module tb_issue_scoreboard;

    localparam int NR         = 16;
    localparam int MODE_RUN   = 0;
    localparam int MODE_DRAIN = 1;
    localparam int MODE_DONE  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        dec_valid_i = 1'b0, dec_ready_o;
    logic [3:0]  rd_i = '0, rs_i = '0;
    logic        immf_i = 1'b0;
    logic [31:0] imm_i = '0;
    logic        rd_rd_i = 1'b0, rd_wr_i = 1'b0;
    logic        iss_valid_o, iss_ready_i = 1'b0;
    logic [3:0]  iss_rd_o, iss_rs_o;
    logic        iss_immf_o;
    logic [31:0] iss_imm_o;
    logic        w_reserved_o;
    logic [3:0]  res_r_o;
    logic        wb_i = 1'b0;
    logic [3:0]  wb_r_i = '0;
    logic [15:0] pending_o;
    logic        flush_i = 1'b0, flush_done_o;
    logic [15:0] stall_cnt_o;

    issue_scoreboard dut (
        .clk(clk), .rst(rst),
        .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
        .rd_i(rd_i), .rs_i(rs_i), .immf_i(immf_i), .imm_i(imm_i),
        .rd_rd_i(rd_rd_i), .rd_wr_i(rd_wr_i),
        .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i),
        .iss_rd_o(iss_rd_o), .iss_rs_o(iss_rs_o),
        .iss_immf_o(iss_immf_o), .iss_imm_o(iss_imm_o),
        .w_reserved_o(w_reserved_o), .res_r_o(res_r_o),
        .wb_i(wb_i), .wb_r_i(wb_r_i), .pending_o(pending_o),
        .flush_i(flush_i), .flush_done_o(flush_done_o),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic        immf;
        logic [31:0] imm;
    } pay_t;

    pay_t        exp_q[$];
    int          n_vec = 0;
    int          n_bad = 0;

    // Reference model state
    bit          m_pend[NR];
    bit          m_valid;
    int unsigned m_stall;
    int          m_mode;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pend_vec();
        logic [15:0] v;
        for (int i = 0; i < NR; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
        m_valid = 1'b0;
        m_stall = 0;
        m_mode  = MODE_RUN;
        exp_q.delete();
    endtask

    // One clock cycle: drive, check combinational response, advance model,
    // check registered state after the edge.
    task automatic step(input bit dv, input logic [3:0] rd, input logic [3:0] rs,
                        input bit immf, input logic [31:0] imm, input bit rdrd,
                        input bit rdwr, input bit ir, input bit wb,
                        input logic [3:0] wbr, input bit fl);
        bit   eff[NR];
        bit   hazard, rdy, acc, drained;
        pay_t p;
        @(negedge clk);
        dec_valid_i = dv; rd_i = rd; rs_i = rs; immf_i = immf; imm_i = imm;
        rd_rd_i = rdrd; rd_wr_i = rdwr; iss_ready_i = ir;
        wb_i = wb; wb_r_i = wbr; flush_i = fl;
        #2;
        for (int i = 0; i < NR; i++) eff[i] = m_pend[i] && !(wb && int'(wbr) == i);
        hazard = (rdrd && eff[rd]) || (!immf && eff[rs]) || (rdwr && eff[rd]);
        rdy    = (m_mode == MODE_RUN) && (!m_valid || ir) && !hazard;
        acc    = dv && rdy;
        check("dec_ready", dec_ready_o, rdy);
        check("w_reserved", w_reserved_o, acc && rdwr);
        if (acc && rdwr) check("res_r", res_r_o, rd);
        if (acc) begin
            p.rd = rd; p.rs = rs; p.immf = immf; p.imm = imm;
            exp_q.push_back(p);
        end
        for (int i = 0; i < NR; i++) m_pend[i] = eff[i];
        if (acc && rdwr) m_pend[rd] = 1'b1;
        if (acc) m_valid = 1'b1;
        else if (ir) m_valid = 1'b0;
        if (dv && !rdy && m_stall != 32'd65535) m_stall++;
        drained = (pend_vec() == 16'h0) && !m_valid;
        case (m_mode)
            MODE_RUN:   if (fl) m_mode = MODE_DRAIN;
            MODE_DRAIN: if (drained) m_mode = MODE_DONE;
            default:    m_mode = MODE_RUN;
        endcase
        @(posedge clk);
        #1;
        check("pending", pending_o, pend_vec());
        check("iss_valid", iss_valid_o, m_valid);
        check("stall_cnt", stall_cnt_o, m_stall);
        check("flush_done", flush_done_o, m_mode == MODE_DONE);
    endtask

    task automatic rand_step();
        bit          dv, immf, rdrd, rdwr, ir, wb, fl;
        logic [3:0]  rd, rs, wbr;
        dv   = ($urandom_range(0, 99) < 80);
        rd   = 4'($urandom_range(0, 7));
        rs   = 4'($urandom_range(0, 7));
        immf = ($urandom_range(0, 99) < 40);
        rdrd = ($urandom_range(0, 99) < 50);
        rdwr = ($urandom_range(0, 99) < 70);
        ir   = ($urandom_range(0, 99) < 70);
        wb   = ($urandom_range(0, 99) < 45);
        wbr  = 4'($urandom_range(0, 7));
        fl   = ($urandom_range(0, 99) < 3);
        step(dv, rd, rs, immf, $urandom, rdrd, rdwr, ir, wb, wbr, fl);
    endtask

    // Scoreboard monitor: whenever the issue register is valid its payload
    // must match the oldest expected entry; a handshake retires it.
    initial begin
        pay_t f;
        forever begin
            @(negedge clk);
            #3;
            if (rst && iss_valid_o) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL iss_payload: got valid entry rd=%0h expected no entry", iss_rd_o);
                end else begin
                    f = exp_q[0];
                    check("iss_rd", iss_rd_o, f.rd);
                    check("iss_rs", iss_rs_o, f.rs);
                    check("iss_immf", iss_immf_o, f.immf);
                    check("iss_imm", iss_imm_o, f.imm);
                    if (iss_ready_i) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_pending", pending_o, 16'h0);
        check("rst_iss_valid", iss_valid_o, 1'b0);
        check("rst_iss_rd", iss_rd_o, 4'h0);
        check("rst_iss_imm", iss_imm_o, 32'h0);
        check("rst_stall", stall_cnt_o, 16'h0);
        check("rst_flush_done", flush_done_o, 1'b0);

        // Back-to-back independent writers r1, r2
        step(1, 4'd1, 4'd0, 1, 32'h1111_0001, 0, 1, 1, 0, 4'd0, 0);
        step(1, 4'd2, 4'd0, 1, 32'h2222_0002, 0, 1, 1, 0, 4'd0, 0);
        check("pending_r1r2", pending_o, 16'h0006);
        // RAW stall on rs=3, released by same-cycle writeback of r3
        step(1, 4'd3, 4'd0, 1, 32'h3333_0003, 0, 1, 1, 0, 4'd0, 0);
        step(1, 4'd4, 4'd3, 0, 32'h4444_0004, 0, 1, 1, 0, 4'd0, 0);
        step(1, 4'd4, 4'd3, 0, 32'h4444_0004, 0, 1, 1, 0, 4'd0, 0);
        step(1, 4'd4, 4'd3, 0, 32'h4444_0004, 0, 1, 1, 1, 4'd3, 0);
        // Same-cycle writeback and new reservation of r5
        step(1, 4'd5, 4'd0, 1, 32'h5555_0005, 0, 1, 1, 0, 4'd0, 0);
        step(1, 4'd5, 4'd0, 1, 32'h5555_0006, 0, 1, 1, 1, 4'd5, 0);
        // Backpressure: three cycles held, then release
        step(1, 4'd6, 4'd0, 1, 32'h6666_0006, 0, 0, 0, 0, 4'd0, 0);
        step(1, 4'd6, 4'd0, 1, 32'h6666_0006, 0, 0, 0, 0, 4'd0, 0);
        step(1, 4'd6, 4'd0, 1, 32'h6666_0006, 0, 0, 0, 0, 4'd0, 0);
        step(1, 4'd6, 4'd0, 1, 32'h6666_0006, 0, 0, 1, 0, 4'd0, 0);
        // Writeback of an unreserved register is ignored
        step(0, 4'd0, 4'd0, 1, 32'h0, 0, 0, 1, 1, 4'd9, 0);
        // Flush: drain outstanding writes r1,r2,r4,r5
        step(0, 4'd0, 4'd0, 1, 32'h0, 0, 0, 1, 1, 4'd1, 1);
        step(1, 4'd7, 4'd0, 1, 32'h7777_0007, 0, 1, 1, 1, 4'd2, 0);
        step(0, 4'd0, 4'd0, 1, 32'h0, 0, 0, 1, 1, 4'd4, 1);
        step(0, 4'd0, 4'd0, 1, 32'h0, 0, 0, 1, 1, 4'd5, 0);
        step(0, 4'd0, 4'd0, 1, 32'h0, 0, 0, 1, 0, 4'd0, 0);
        step(0, 4'd0, 4'd0, 1, 32'h0, 0, 0, 1, 0, 4'd0, 0);

        for (int n = 0; n < 3000; n++) rand_step();

        // Settle, then reserve every register and start a drain
        for (int i = 0; i < NR; i++) step(0, 4'd0, 4'd0, 1, 32'h0, 0, 0, 1, 1, 4'(i), 0);
        repeat (4) step(0, 4'd0, 4'd0, 1, 32'h0, 0, 0, 1, 0, 4'd0, 0);
        for (int i = 0; i < NR; i++) step(1, 4'(i), 4'd0, 1, $urandom, 0, 1, 1, 0, 4'd0, 0);
        check("pending_all", pending_o, 16'hFFFF);
        step(0, 4'd0, 4'd0, 1, 32'h0, 0, 0, 1, 0, 4'd0, 1);
        step(1, 4'd0, 4'd0, 1, 32'h0, 0, 0, 1, 0, 4'd0, 0);

        // Asynchronous reset in the middle of a cycle while draining
        @(negedge clk);
        dec_valid_i = 1'b0;
        #4;
        rst = 1'b0;
        #1;
        check("arst_pending", pending_o, 16'h0);
        check("arst_iss_valid", iss_valid_o, 1'b0);
        check("arst_flush_done", flush_done_o, 1'b0);
        check("arst_stall", stall_cnt_o, 16'h0);
        model_reset();
        repeat (2) begin
            @(posedge clk);
            #1;
            check("arst_hold_flush_done", flush_done_o, 1'b0);
            check("arst_hold_pending", pending_o, 16'h0);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) step(0, 4'd0, 4'd0, 1, 32'h0, 0, 0, 1, 0, 4'd0, 0);

        for (int n = 0; n < 300; n++) rand_step();

        check("queue_vs_valid", 64'(exp_q.size()), 64'(m_valid));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no completion expected finish before limit");
        $fatal(1);
    end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Sits between insn_decoder and the execute stage.
- Gates decoded instructions into a one-entry issue register and tracks outstanding destination writes per general register. It stalls on RAW/WAW hazards and clears reservations on writeback.
- Drives the reservation inputs of register_general and provides a drain/flush sequence for control-flow changes.

Parameters:
- LEN_REGNO, 4, register-number width; NUM_REG = 2**LEN_REGNO
- LEN_IMM_EX, 32, width of the extended immediate carried through
- LEN_STALLCNT, 16, width of the saturating stall counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- dec_valid_i  in  1  decoder holds a valid instruction
- dec_ready_o  out  1  instruction accepted this cycle
- rd_i  in  LEN_REGNO  destination / first source register
- rs_i  in  LEN_REGNO  second source register
- immf_i  in  1  1: immediate replaces rs (rs not read)
- imm_i  in  LEN_IMM_EX  extended immediate
- rd_rd_i  in  1  instruction reads rd as a source
- rd_wr_i  in  1  instruction writes rd
- iss_valid_o  out  1  issue register valid
- iss_ready_i  in  1  execute stage accepts
- iss_rd_o, iss_rs_o  out  LEN_REGNO  issued register numbers
- iss_immf_o  out  1  issued immediate flag
- iss_imm_o  out  LEN_IMM_EX  issued immediate
- w_reserved_o  out  1  to register_general w_reserved_i: reservation set this cycle
- res_r_o  out  LEN_REGNO  register being reserved
- wb_i  in  1  writeback strobe
- wb_r_i  in  LEN_REGNO  writeback register
- pending_o  out  NUM_REG  pending-write bit vector
- flush_i  in  1  request drain
- flush_done_o  out  1  one-cycle pulse when drained
- stall_cnt_o  out  LEN_STALLCNT  cycles with dec_valid_i=1 and dec_ready_o=0

Behaviour:
- Reset (rst=0, asynchronous): pending=0, iss_valid_o=0, issue payload=0, state=RUN, stall_cnt_o=0, flush_done_o=0.
- Effective pending: pend_eff = pending & ~(wb_i ? onehot(wb_r_i) : 0). Writeback bypasses the hazard check in the same cycle.
- Hazard is asserted when any of the following holds:
  - rd_rd_i and pend_eff[rd_i] (RAW on rd)
  - !immf_i and pend_eff[rs_i] (RAW on rs)
  - rd_wr_i and pend_eff[rd_i] (WAW)
- Issue register is free when iss_valid_o=0 or iss_ready_i=1.
- dec_ready_o = (state==RUN) & free & !hazard. It is combinational and independent of dec_valid_i.
- Accept (dec_valid_i & dec_ready_o):
  - At the next edge the issue register loads the payload and iss_valid_o=1.
  - Latency decoder→issue is 1 cycle.
  - If rd_wr_i, the pending bit for rd_i is set.
- w_reserved_o = accept & rd_wr_i; res_r_o = rd_i. Both are combinational, in the same cycle as accept.
- Issue handshake:
  - iss_valid_o & iss_ready_i retires the entry; iss_valid_o drops unless a new accept happens in the same cycle.
  - While iss_valid_o=1 and iss_ready_i=0, the payload stays stable.
- Pending update per edge: pending_next = pend_eff | set_mask. If the same register is written back and reserved in the same cycle, the set wins.
- A writeback to a register whose pending bit is clear is ignored. No error is raised.
- Stall counter increments when dec_valid_i & !dec_ready_o and saturates at all-ones.
- FSM:
  - RUN: on flush_i → DRAIN. Acceptance stops from that cycle, since dec_ready_o is gated by state.
  - DRAIN: wait until pending==0 and iss_valid_o==0 (evaluated on next-state values), then → DONE. flush_i is ignored in DRAIN.
  - DONE: flush_done_o=1 for exactly this cycle; → RUN.
  - flush_done_o is registered; it is 1 only while state==DONE.
- Reset mid-DRAIN returns the block to RUN with everything cleared. No flush_done_o pulse is produced.

Decomposition:
- Shared package defs_insn.v already holds LEN_REGNO, LEN_IMM_EX and the shift constants.
- Add to the same package:
  - the FSM state encodings: ISB_RUN=2'd0, ISB_DRAIN=2'd1, ISB_DONE=2'd2
  - NUM_REG
- One natural sub-module, scoreboard_bits. It holds the NUM_REG pending flops with set/clear ports and supplies the bypassed hazard lookups for rd and rs.

Test Plan:
- Back-to-back independent instructions:
  - Stimulus: issue r1←imm, then r2←imm, with iss_ready_i=1.
  - Response: both accepted on consecutive cycles; pending_o=0x0006 after the second edge; w_reserved_o pulses with res_r_o=1, then 2.
- RAW stall:
  - Stimulus: write r3, then an instruction with rs=3 and immf=0.
  - Response: dec_ready_o=0 and stall_cnt_o increments each cycle; wb_i=1 with wb_r_i=3 gives dec_ready_o=1 in that same cycle.
- Same-cycle set/clear on r5:
  - Stimulus: pending[5]=1; a new writer to r5 is accepted in the cycle wb_r_i=5 arrives.
  - Response: pending[5] stays 1.
- Backpressure:
  - Stimulus: iss_ready_i=0 for 3 cycles with a valid entry.
  - Response: iss_rd_o/iss_imm_o stable and dec_ready_o=0; on release, the next instruction issues 1 cycle later.
- Flush:
  - Stimulus: pending=0x0010 and flush_i=1.
  - Response: DRAIN; dec_ready_o=0; wb r4 → DONE next edge; flush_done_o is high for exactly 1 cycle, then RUN.
- Reset mid-operation:
  - Stimulus: drop rst asynchronously during DRAIN with pending=0xFFFF.
  - Response: outputs clear immediately; pending_o=0, iss_valid_o=0, flush_done_o never pulses.
